// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the RV64M multiply/divide execution unit.
package riscv_muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    localparam logic [6:0] MULDIV_FUNC7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Divide-class ops all have Func3[2] set.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/riscv_muldiv_unit.sv
// Multi-cycle RV64M unit: 1 bit/cycle shift-add multiplier and restoring divider
// sharing one hi/lo shift register pair, behind a valid/ready request/response pair.
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req_Valid,
    output logic            Req_Ready,
    input  logic [2:0]      Func3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            Resp_Valid,
    input  logic            Resp_Ready,
    output logic [XLEN-1:0] Result,
    output logic            Busy
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state_q, state_d;

    logic [2:0]      op_q;
    logic            neg_res_q;   // product / quotient needs negation
    logic            neg_rem_q;   // remainder takes the sign of A
    logic [XLEN-1:0] opnd_q;      // multiplicand (mul) or divisor (div)
    logic [XLEN-1:0] hi_q;        // product high half / partial remainder
    logic [XLEN-1:0] lo_q;        // multiplier -> product low / dividend -> quotient
    logic [CNT_W-1:0] cnt_q;

    logic            accept;
    logic            is_div;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   hi_next, lo_next;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Request decode: operand signs, magnitudes and early-out cases.
    always_comb begin
        accept   = Req_Valid && Req_Ready;
        is_div   = is_div_op(Func3);
        a_signed = (Func3 == F3_MUL) || (Func3 == F3_MULH) || (Func3 == F3_MULHSU) ||
                   (Func3 == F3_DIV) || (Func3 == F3_REM);
        b_signed = (Func3 == F3_MUL) || (Func3 == F3_MULH) ||
                   (Func3 == F3_DIV) || (Func3 == F3_REM);
        a_neg    = a_signed && A[XLEN-1];
        b_neg    = b_signed && B[XLEN-1];
        a_mag    = a_neg ? (~A + XLEN'(1)) : A;
        b_mag    = b_neg ? (~B + XLEN'(1)) : B;
        div_zero = is_div && (B == '0);
        div_ovf  = ((Func3 == F3_DIV) || (Func3 == F3_REM)) && (A == INT_MIN) && (B == '1);
        special  = div_zero || div_ovf;
        // Func3[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = Func3[1] ? A : '1;
        end else begin
            special_res = Func3[1] ? '0 : A;
        end
    end

    // One iteration of shift-add multiply or restoring divide, plus sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_ge    = !div_trial[XLEN];
        if (is_div_op(op_q)) begin
            hi_next = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_next = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_q, lo_q};
        prod_fix = neg_res_q ? (~prod + (2*XLEN)'(1)) : prod;
        quo_fix  = neg_res_q ? (~lo_q + XLEN'(1)) : lo_q;
        rem_fix  = neg_rem_q ? (~hi_q + XLEN'(1)) : hi_q;
        if (is_div_op(op_q)) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_res = (op_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (Resp_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Req_Ready  <= 1'b1;
            Resp_Valid <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Req_Ready  <= (state_d == IDLE);
            Resp_Valid <= (state_d == DONE);
            Busy       <= (state_d != IDLE);
        end
    end

    // Operand latch, iteration registers and result register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            Result    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= Func3;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        opnd_q    <= is_div ? b_mag : a_mag;
                        lo_q      <= is_div ? a_mag : b_mag;
                        hi_q      <= '0;
                        cnt_q     <= '0;
                        if (special) begin
                            Result <= special_res;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= hi_next;
                    lo_q  <= lo_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    Result <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule
